// File: rtl/commit_trace_buffer.sv
// Retire-stage trace monitor: captures MEM/WB commit events as cycle-stamped
// records in a FIFO drained over valid/ready, with on-chip cycle/inst/drop counters.
module commit_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     reg_wrt,
    input  logic [REG_AW-1:0]        reg_dst,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     mem_rd,
    input  logic                     mem_wrt,
    input  logic [DATA_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     hlt,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [3:0]               trc_flags,
    output logic [DATA_W-1:0]        trc_pc,
    output logic [REG_AW-1:0]        trc_reg_dst,
    output logic [DATA_W-1:0]        trc_reg_data,
    output logic [DATA_W-1:0]        trc_mem_addr,
    output logic [DATA_W-1:0]        trc_mem_data,
    output logic [CNT_W-1:0]         trc_stamp,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         inst_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic                     halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]        flags;
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] mdata;
        logic [CNT_W-1:0]  stamp;
    } rec_t;

    rec_t              mem_r [DEPTH];
    rec_t              head_r;
    rec_t              rec_s;
    logic              trc_valid_r;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [LVL_W-1:0]  level_r, level_nxt_s;
    logic [CNT_W-1:0]  cycle_count_r, inst_count_r, drop_count_r;
    logic              overflow_r, halted_r;
    logic              active_s, event_s, full_s, pop_s, push_s, drop_s;
    logic              store_s, load_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Event decode, record assembly and next FIFO pointer/occupancy state.
    always_comb begin
        active_s = en & ~halted_r;
        event_s  = active_s & (reg_wrt | mem_rd | mem_wrt | hlt);
        full_s   = (level_r == LVL_W'(DEPTH));
        pop_s    = trc_valid_r & trc_ready;
        push_s   = event_s & (~full_s | pop_s);
        drop_s   = event_s & full_s & ~pop_s;
        store_s  = mem_wrt;
        load_s   = mem_rd & ~mem_wrt;

        rec_s.flags = {hlt, store_s, load_s, reg_wrt};
        rec_s.pc    = pc_in;
        rec_s.dst   = reg_dst;
        rec_s.rdata = reg_data;
        rec_s.addr  = mem_addr;
        rec_s.stamp = cycle_count_r;
        if (store_s) begin
            rec_s.mdata = mem_wdata;
        end else if (load_s) begin
            rec_s.mdata = mem_rdata;
        end else begin
            rec_s.mdata = {DATA_W{1'b0}};
        end

        wr_ptr_nxt_s = push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end
    end

    // Control state, counters and the registered head record.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            level_r       <= {LVL_W{1'b0}};
            trc_valid_r   <= 1'b0;
            head_r        <= '0;
            cycle_count_r <= {CNT_W{1'b0}};
            inst_count_r  <= {CNT_W{1'b0}};
            drop_count_r  <= {CNT_W{1'b0}};
            overflow_r    <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            trc_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
            // A record landing in the slot that becomes head is forwarded from the write path.
            if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                head_r <= rec_s;
            end else begin
                head_r <= mem_r[rd_ptr_nxt_s];
            end
            if (active_s) begin
                cycle_count_r <= sat_inc(cycle_count_r);
            end
            if (active_s && (hlt || reg_wrt || mem_wrt)) begin
                inst_count_r <= sat_inc(inst_count_r);
            end
            if (drop_s) begin
                drop_count_r <= sat_inc(drop_count_r);
                overflow_r   <= 1'b1;
            end
            if (active_s && hlt) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign trc_valid    = trc_valid_r;
    assign trc_flags    = head_r.flags;
    assign trc_pc       = head_r.pc;
    assign trc_reg_dst  = head_r.dst;
    assign trc_reg_data = head_r.rdata;
    assign trc_mem_addr = head_r.addr;
    assign trc_mem_data = head_r.mdata;
    assign trc_stamp    = head_r.stamp;
    assign level        = level_r;
    assign cycle_count  = cycle_count_r;
    assign inst_count   = inst_count_r;
    assign drop_count   = drop_count_r;
    assign overflow     = overflow_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a reference model predicts counters and
// queues expected records, which are compared against the head on every pop.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst, en, reg_wrt, mem_rd, mem_wrt, hlt, trc_ready;
    logic [15:0] pc_in, reg_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  reg_dst;
    logic        trc_valid, overflow, halted;
    logic [3:0]  trc_flags, trc_reg_dst;
    logic [15:0] trc_pc, trc_reg_data, trc_mem_addr, trc_mem_data;
    logic [31:0] trc_stamp, cycle_count, inst_count, drop_count;
    logic [3:0]  level;

    commit_trace_buffer #(.DATA_W(16), .REG_AW(4), .DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .pc_in(pc_in), .reg_wrt(reg_wrt),
        .reg_dst(reg_dst), .reg_data(reg_data), .mem_rd(mem_rd), .mem_wrt(mem_wrt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_flags(trc_flags),
        .trc_pc(trc_pc), .trc_reg_dst(trc_reg_dst), .trc_reg_data(trc_reg_data),
        .trc_mem_addr(trc_mem_addr), .trc_mem_data(trc_mem_data), .trc_stamp(trc_stamp),
        .level(level), .cycle_count(cycle_count), .inst_count(inst_count),
        .drop_count(drop_count), .overflow(overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  flags;
        logic [15:0] pc;
        logic [3:0]  dst;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [31:0] stamp;
    } rec_t;

    rec_t        q[$];
    rec_t        exp_rec;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cycle, m_inst, m_drop;
    logic        m_ovf, m_halted;
    logic [3:0]  last_flags;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check/pop head, advance model, then check state.
    task automatic step(input logic r, e, rw, mr, mw, h, rdy,
                        input logic [15:0] pc, input logic [3:0] dst,
                        input logic [15:0] rdat, ad, wd, md);
        logic act, ev, pop;
        rec_t rec;
        rst = r; en = e; reg_wrt = rw; mem_rd = mr; mem_wrt = mw; hlt = h;
        trc_ready = rdy; pc_in = pc; reg_dst = dst; reg_data = rdat;
        mem_addr = ad; mem_wdata = wd; mem_rdata = md;
        if (!r) begin
            chk("valid_pre", trc_valid, q.size() != 0);
            pop = rdy && (q.size() != 0);
            if (pop) begin
                rec = q.pop_front();
                chk("record", {trc_flags, trc_pc, trc_reg_dst, trc_reg_data,
                               trc_mem_addr, trc_mem_data, trc_stamp}, rec);
                last_flags = trc_flags;
            end
            act = e && !m_halted;
            ev  = act && (rw || mr || mw || h);
            if (ev) begin
                rec.flags = {h, mw, mr & ~mw, rw};
                rec.pc = pc; rec.dst = dst; rec.rdata = rdat; rec.addr = ad;
                rec.mdata = mw ? wd : (mr ? md : 16'h0000);
                rec.stamp = m_cycle;
                if (q.size() < 8) q.push_back(rec);
                else begin m_drop++; m_ovf = 1'b1; end
            end
            if (act) m_cycle++;
            if (act && (h || rw || mw)) m_inst++;
            if (act && h) m_halted = 1'b1;
        end else begin
            q.delete();
            m_cycle = 32'd0; m_inst = 32'd0; m_drop = 32'd0;
            m_ovf = 1'b0; m_halted = 1'b0;
        end
        @(posedge clk); #1;
        chk("level", level, q.size());
        chk("valid", trc_valid, q.size() != 0);
        chk("cycle_count", cycle_count, m_cycle);
        chk("inst_count", inst_count, m_inst);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("halted", halted, m_halted);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             16'hFFFF, 4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rdy,
             16'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic ev_reg(input logic [15:0] pc, input logic [3:0] dst,
                          input logic [15:0] d, input logic rdy);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rdy, pc, dst, d, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        m_cycle = 32'd0; m_inst = 32'd0; m_drop = 32'd0;
        m_ovf = 1'b0; m_halted = 1'b0; last_flags = 4'h0;

        // Reset for two cycles; events asserted alongside must be ignored.
        do_rst();
        do_rst();
        chk("rst_data", {trc_flags, trc_pc, trc_reg_dst, trc_reg_data,
                         trc_mem_addr, trc_mem_data, trc_stamp}, 128'd0);

        // Basic record.
        ev_reg(16'h0004, 4'd3, 16'h00A5, 1'b0);
        chk("basic_valid", trc_valid, 1'b1);
        chk("basic_flags", trc_flags, 4'b0001);
        chk("basic_stamp", trc_stamp, 32'd0);
        chk("basic_dst", trc_reg_dst, 4'd3);
        idle(1'b1);
        chk("basic_level", level, 4'd0);
        chk("basic_inst", inst_count, 32'd1);

        // Load, then load+store (store wins).
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
             16'h0008, 4'h0, 16'h0, 16'h0010, 16'h0, 16'h1234);
        chk("load_flags", trc_flags, 4'b0010);
        chk("load_data", trc_mem_data, 16'h1234);
        chk("load_inst", inst_count, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
             16'h000C, 4'h0, 16'h0, 16'h0020, 16'hBEEF, 16'h5555);
        chk("store_inst", inst_count, 32'd2);
        idle(1'b1);
        chk("store_flags", trc_flags, 4'b0100);
        chk("store_data", trc_mem_data, 16'hBEEF);
        idle(1'b1);
        // Disabled cycle: no capture, counters frozen.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             16'h0040, 4'h1, 16'h1111, 16'h0, 16'h0, 16'h0);

        // Overflow: 10 events into 8 entries, then drain stamps 0..7.
        do_rst();
        for (int i = 0; i < 10; i++) ev_reg(16'h0100 + 16'(i), 4'(i), 16'(i * 3 + 1), 1'b0);
        chk("ovf_level", level, 4'd8);
        chk("ovf_drop", drop_count, 32'd2);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Full with simultaneous push and pop across the pointer wrap.
        do_rst();
        for (int i = 0; i < 8; i++) ev_reg(16'h0200 + 16'(i), 4'(i), 16'(i + 16'h0300), 1'b0);
        for (int i = 0; i < 5; i++) ev_reg(16'h0280 + 16'(i), 4'(i + 8), 16'(i + 16'h0400), 1'b1);
        chk("full_level", level, 4'd8);
        chk("full_drop", drop_count, 32'd0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Halt at cycle 20 with further events at 21..25.
        do_rst();
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) ev_reg(16'h0500 + 16'(i), 4'(i), 16'(i), 1'b0);
            else idle(1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             16'h0600, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) ev_reg(16'h0700 + 16'(i), 4'(i), 16'(i), 1'b0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_cycle", cycle_count, 32'd21);
        chk("halt_inst", inst_count, 32'd6);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("halt_last_flags", last_flags, 4'b1000);
        chk("halt_drained", level, 4'd0);

        // Reset while holding entries, halted and overflowed.
        do_rst();
        for (int i = 0; i < 9; i++) ev_reg(16'h0800 + 16'(i), 4'(i), 16'(i), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             16'h0900, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("mid_level", level, 4'd5);
        chk("mid_halted", halted, 1'b1);
        chk("mid_ovf", overflow, 1'b1);
        do_rst();
        chk("mid_rst_data", {trc_flags, trc_pc, trc_reg_dst, trc_reg_data,
                             trc_mem_addr, trc_mem_data, trc_stamp}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retire-stage trace monitor for the pipelined `cpu`. It samples the MEM/WB commit signals every cycle: register write, load, store and halt. Each cycle with a commit event becomes a cycle-stamped record in a parametrised FIFO, which a host or debug port drains through a valid/ready handshake. It keeps the cycle, instruction and dropped-record counters on chip, so a trace survives on silicon and not only in simulation.

## Interface
Parameters:
- `DATA_W`, 16: width of PC, register data, memory address and memory data.
- `REG_AW`, 4: register index width.
- `DEPTH`, 8: FIFO entries; a power of two, ≥2.
- `CNT_W`, 32: width of all counters and of the cycle stamp.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: capture and count enable.
- `pc_in` in DATA_W: PC of the committing instruction.
- `reg_wrt` in 1: register write committing this cycle.
- `reg_dst` in REG_AW: register index being written.
- `reg_data` in DATA_W: data being written to the register.
- `mem_rd` in 1: memory read this cycle.
- `mem_wrt` in 1: memory write this cycle.
- `mem_addr` in DATA_W: memory address.
- `mem_wdata` in DATA_W: store data.
- `mem_rdata` in DATA_W: load data.
- `hlt` in 1: halt instruction committing.
- `trc_valid` out 1: head record present.
- `trc_ready` in 1: consumer accepts head record.
- `trc_flags` out 4: {hlt, store, load, regwr} of the head record.
- `trc_pc`, `trc_reg_dst`, `trc_reg_data`, `trc_mem_addr`, `trc_mem_data` out: head record fields, same widths as the inputs.
- `trc_stamp` out CNT_W: cycle stamp of the head record.
- `level` out log2(DEPTH)+1: current occupancy.
- `cycle_count`, `inst_count`, `drop_count` out CNT_W: counters.
- `overflow` out 1: sticky; at least one record dropped.
- `halted` out 1: a halt record has been captured.

## Operation
- Active cycle: `en & ~halted`.
- Event: `reg_wrt | mem_rd | mem_wrt | hlt` in an active cycle.
- Flag mapping:
  - store = `mem_wrt`.
  - load = `mem_rd & ~mem_wrt`; the store wins when both are asserted.
  - regwr = `reg_wrt`.
  - hlt = `hlt`.
- `trc_mem_data` takes `mem_wdata` when store=1, else `mem_rdata` when load=1, else 0.
- Non-flagged fields are stored as given; consumers ignore them.
- `cycle_count`: increments on every active cycle and saturates at all-ones.
- `trc_stamp`: the `cycle_count` value before the increment in the capture cycle. The first active cycle after reset stamps 0.
- `inst_count`: increments on active cycles with `hlt | reg_wrt | mem_wrt`, and saturates. A load without a register write is not counted.
- Push: on every event while the FIFO is not full, or while full with a pop in the same cycle.
- Drop: an event while full with no pop discards the record, increments `drop_count` (saturating) and sets `overflow`. `overflow` clears only on `rst`.
- Pop: `trc_valid & trc_ready`. The head advances; pointers wrap modulo DEPTH.
- Halt:
  - The hlt record is pushed like any other record, or dropped if the FIFO is full.
  - `halted` sets at the end of that cycle regardless of push or drop.
  - Afterwards, capture and all counters freeze.
  - The FIFO continues to drain.
  - Only `rst` leaves the halted state.
- Deasserting `en` freezes capture and counters without losing FIFO contents.

## Timing
- Reset values: `trc_valid`=0, `level`=0, all counters 0, `overflow`=0, `halted`=0, all `trc_*` data outputs 0.
- An asserted `rst` overrides all same-cycle events. Reset mid-drain discards all entries.
- Push-to-visible latency:
  - A record captured at edge N appears with `trc_valid`=1 after edge N.
  - There is no fall-through in the capture cycle.
- Outputs are registered from FIFO storage. The head fields are stable while `trc_valid & ~trc_ready`.
- Full (`level`=DEPTH) with simultaneous push and pop: both occur, `level` stays DEPTH, nothing is dropped.
- Empty with a push: `level` becomes 1. A pop when empty is ignored.
- Pointer wrap-around at DEPTH-1 → 0 is seamless; there is no lost or duplicated entry.

## Test plan
- **Basic record:** reset 2 cycles, then `reg_wrt`=1, `reg_dst`=3, `reg_data`=0x00A5, `pc_in`=0x0004 in the first active cycle.
  - Next cycle: `trc_valid`=1, flags=0001, stamp=0.
  - After the pop: `level`=0, `inst_count`=1.
- **Load vs store:** a load (addr 0x0010, rdata 0x1234) and then a cycle with `mem_rd`=`mem_wrt`=1 (wdata 0xBEEF).
  - Load record: flags=0010, data=0x1234.
  - Store record: flags=0100, data=0xBEEF.
  - `inst_count` increments only for the store.
- **Overflow:** DEPTH=8, `trc_ready`=0, 10 consecutive events → `level`=8, `drop_count`=2, `overflow`=1. Draining returns records stamped 0–7 in order.
- **Full with simultaneous push/pop:** FIFO full, `trc_ready`=1 plus an event for 5 cycles → `level` holds 8, `drop_count`=0, order preserved across the pointer wrap.
- **Halt:** hlt at cycle 20 with further events at 21–25.
  - `halted`=1 from cycle 21.
  - `cycle_count` freezes at 21 and `inst_count` stops.
  - The FIFO drains fully; the last record has flags=1000.
- **Reset mid-operation:** `rst` while `level`=5, `halted`=1 and `overflow`=1 → every output returns to its reset value on the next edge.
